// File: rtl/cycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cycle_sequencer
//  Description : Major-cycle sequencer. Walks each instruction through fetch,
//                optional autoindex / indirect and three execute cycles as
//                ck/stb phase pairs, with run/step control and interrupt
//                pseudo-instruction insertion at instruction boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module cycle_sequencer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic       instIsIND,
  input  logic       instIsPPIND,
  input  logic       irqReq,
  input  logic       irqEn,
  output logic       ckFetch,
  output logic       stbFetch,
  output logic       ckAuto1,
  output logic       stbAuto1,
  output logic       ckAuto2,
  output logic       stbAuto2,
  output logic       ckInd,
  output logic       stbInd,
  output logic       ckExec1,
  output logic       stbExec1,
  output logic       ckExec2,
  output logic       stbExec2,
  output logic       ckExec3,
  output logic       stbExec3,
  output logic       irqOverride,
  output logic       irqAck,
  output logic       running,
  output logic [3:0] cycleState
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    F_CK  = 4'd1,
    F_ST  = 4'd2,
    A1_CK = 4'd3,
    A1_ST = 4'd4,
    A2_CK = 4'd5,
    A2_ST = 4'd6,
    I_CK  = 4'd7,
    I_ST  = 4'd8,
    E1_CK = 4'd9,
    E1_ST = 4'd10,
    E2_CK = 4'd11,
    E2_ST = 4'd12,
    E3_CK = 4'd13,
    E3_ST = 4'd14
  } state_t;

  state_t state;
  state_t state_next;
  logic   running_next;
  logic   override_next;
  logic   ack_next;
  logic   pp_eff;
  logic   ind_eff;
  logic   run_on;

  // Next-state decode; the interrupt pseudo-instruction masks the decode
  // flags so it always takes the direct path.
  always_comb begin
    state_next    = state;
    running_next  = running & ~stop;
    override_next = irqOverride;
    ack_next      = 1'b0;
    pp_eff        = instIsPPIND & ~irqOverride;
    ind_eff       = instIsIND & ~irqOverride;
    run_on        = running & ~stop;
    case (state)
      IDLE: begin
        if (start) begin
          if (!stop) begin
            state_next   = F_CK;
            running_next = 1'b1;
          end
        end else if (step) begin
          state_next = F_CK;
        end
      end
      F_CK:  state_next = F_ST;
      F_ST: begin
        if (pp_eff)       state_next = A1_CK;
        else if (ind_eff) state_next = I_CK;
        else              state_next = E1_CK;
      end
      A1_CK: state_next = A1_ST;
      A1_ST: state_next = A2_CK;
      A2_CK: state_next = A2_ST;
      A2_ST: state_next = I_CK;
      I_CK:  state_next = I_ST;
      I_ST:  state_next = E1_CK;
      E1_CK: state_next = E1_ST;
      E1_ST: state_next = E2_CK;
      E2_CK: state_next = E2_ST;
      E2_ST: state_next = E3_CK;
      E3_CK: state_next = E3_ST;
      E3_ST: begin
        // Instruction boundary: the only point where run and irq are honoured.
        override_next = 1'b0;
        if (run_on) begin
          state_next = F_CK;
          if (irqReq && irqEn) begin
            override_next = 1'b1;
            ack_next      = 1'b1;
          end
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register with every output registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      running     <= 1'b0;
      irqOverride <= 1'b0;
      irqAck      <= 1'b0;
      cycleState  <= 4'd0;
      ckFetch     <= 1'b0;
      stbFetch    <= 1'b0;
      ckAuto1     <= 1'b0;
      stbAuto1    <= 1'b0;
      ckAuto2     <= 1'b0;
      stbAuto2    <= 1'b0;
      ckInd       <= 1'b0;
      stbInd      <= 1'b0;
      ckExec1     <= 1'b0;
      stbExec1    <= 1'b0;
      ckExec2     <= 1'b0;
      stbExec2    <= 1'b0;
      ckExec3     <= 1'b0;
      stbExec3    <= 1'b0;
    end else begin
      state       <= state_next;
      running     <= running_next;
      irqOverride <= override_next;
      irqAck      <= ack_next;
      cycleState  <= state_next;
      ckFetch     <= (state_next == F_CK);
      stbFetch    <= (state_next == F_ST);
      ckAuto1     <= (state_next == A1_CK);
      stbAuto1    <= (state_next == A1_ST);
      ckAuto2     <= (state_next == A2_CK);
      stbAuto2    <= (state_next == A2_ST);
      ckInd       <= (state_next == I_CK);
      stbInd      <= (state_next == I_ST);
      ckExec1     <= (state_next == E1_CK);
      stbExec1    <= (state_next == E1_ST);
      ckExec2     <= (state_next == E2_CK);
      stbExec2    <= (state_next == E2_ST);
      ckExec3     <= (state_next == E3_CK);
      stbExec3    <= (state_next == E3_ST);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cycle_sequencer
//  Description : Self-checking bench for cycle_sequencer. A queue of expected
//                cycle codes per instruction serves as the reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cycle_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  logic start, stop, step, instIsIND, instIsPPIND, irqReq, irqEn;
  logic ckFetch, stbFetch, ckAuto1, stbAuto1, ckAuto2, stbAuto2, ckInd, stbInd;
  logic ckExec1, stbExec1, ckExec2, stbExec2, ckExec3, stbExec3;
  logic irqOverride, irqAck, running;
  logic [3:0] cycleState;

  int checks = 0;
  int passes = 0;

  // Reference model: remaining cycle codes of the current instruction.
  int q[$];
  bit m_run, m_ovr, m_ack;

  cycle_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .step(step),
    .instIsIND(instIsIND), .instIsPPIND(instIsPPIND), .irqReq(irqReq), .irqEn(irqEn),
    .ckFetch(ckFetch), .stbFetch(stbFetch), .ckAuto1(ckAuto1), .stbAuto1(stbAuto1),
    .ckAuto2(ckAuto2), .stbAuto2(stbAuto2), .ckInd(ckInd), .stbInd(stbInd),
    .ckExec1(ckExec1), .stbExec1(stbExec1), .ckExec2(ckExec2), .stbExec2(stbExec2),
    .ckExec3(ckExec3), .stbExec3(stbExec3), .irqOverride(irqOverride), .irqAck(irqAck),
    .running(running), .cycleState(cycleState)
  );

  always #5 clk = ~clk;

  function automatic int cur_code();
    return (q.size() > 0) ? q[0] : 0;
  endfunction

  function automatic void push_seq(input int lo, input int hi);
    for (int c = lo; c <= hi; c++) q.push_back(c);
  endfunction

  function automatic void model_reset();
    q.delete();
    m_run = 1'b0;
    m_ovr = 1'b0;
    m_ack = 1'b0;
  endfunction

  // Instruction = F pair, optional A1/A2/I or I pairs, then E1..E3 pairs.
  function automatic void model_step(input bit st, input bit sp, input bit stp,
                                     input bit ind, input bit pp, input bit rq, input bit en);
    int cur = cur_code();
    bit nrun = m_run & ~sp;
    m_ack = 1'b0;
    if (cur == 0) begin
      if (st) begin
        if (!sp) begin
          nrun = 1'b1;
          push_seq(1, 2);
        end
      end else if (stp) begin
        push_seq(1, 2);
      end
    end else if (cur == 2) begin
      void'(q.pop_front());
      if (!m_ovr && pp)       push_seq(3, 8);
      else if (!m_ovr && ind) push_seq(7, 8);
      push_seq(9, 14);
    end else if (cur == 14) begin
      void'(q.pop_front());
      m_ovr = 1'b0;
      if (m_run && !sp) begin
        push_seq(1, 2);
        if (rq && en) begin
          m_ovr = 1'b1;
          m_ack = 1'b1;
        end
      end
    end else begin
      void'(q.pop_front());
    end
    m_run = nrun;
  endfunction

  function automatic logic [20:0] obs_vec();
    return {cycleState, running, irqOverride, irqAck,
            stbExec3, ckExec3, stbExec2, ckExec2, stbExec1, ckExec1,
            stbInd, ckInd, stbAuto2, ckAuto2, stbAuto1, ckAuto1, stbFetch, ckFetch};
  endfunction

  function automatic logic [20:0] exp_vec();
    int code = cur_code();
    logic [3:0] c4 = 4'(code);
    logic [13:0] ph = '0;
    if (code != 0) ph[code-1] = 1'b1;
    return {c4, m_run, m_ovr, m_ack, ph};
  endfunction

  // Drive one clock's inputs (from the falling edge), advance the model,
  // and return on the next falling edge.
  task automatic tick(input bit st, input bit sp, input bit stp,
                      input bit ind, input bit pp, input bit rq, input bit en);
    start = st; stop = sp; step = stp;
    instIsIND = ind; instIsPPIND = pp; irqReq = rq; irqEn = en;
    model_step(st, sp, stp, ind, pp, rq, en);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 0; stop = 0; step = 0; instIsIND = 0; instIsPPIND = 0; irqReq = 0; irqEn = 0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs_vec() !== 21'h0) $display("FAIL reset_state: got %h want %h", obs_vec(), 21'h0);
    else passes++;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 1, 1, 1, 1);
      checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL reset_idle cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      else passes++;
    end
  endtask

  task automatic test_step_direct();
    int busy = 0;
    tick(0, 0, 1, 0, 0, 1, 1);
    checks++;
    if (obs_vec() !== exp_vec()) $display("FAIL step_first: got %h want %h", obs_vec(), exp_vec());
    else passes++;
    if (cycleState != 0) busy++;
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 0, 0, 1, 1);
      checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL step_direct cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      else passes++;
      if (cycleState != 0) busy++;
    end
    checks++;
    if (busy !== 8) $display("FAIL step_latency: got %0d want %0d", busy, 8);
    else passes++;
  endtask

  task automatic test_autoindex_stop();
    int busy = 0;
    int n = 0;
    bit saw_e3 = 0;
    tick(1, 0, 0, 1, 1, 0, 0);
    if (cycleState != 0) busy++;
    for (int i = 0; i < 13; i++) begin
      tick(0, 0, 0, 1, 1, 0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL autoindex cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      else passes++;
      if (cycleState != 0) busy++;
    end
    checks++;
    if (busy !== 14 || stbExec3 !== 1'b1) $display("FAIL autoindex_latency: got %0d/%b want 14/1", busy, stbExec3);
    else passes++;
    tick(0, 0, 0, 1, 1, 0, 0);
    checks++;
    if (ckFetch !== 1'b1) $display("FAIL autoindex_next_fetch: got %b want 1", ckFetch);
    else passes++;
    while (cur_code() != 5 && n < 20) begin
      tick(0, 0, 0, 1, 1, 0, 0);
      n++;
    end
    checks++;
    if (ckAuto2 !== 1'b1) $display("FAIL reach_a2ck: got %b want 1", ckAuto2);
    else passes++;
    tick(0, 1, 0, 1, 1, 0, 0);
    checks++;
    if (running !== 1'b0) $display("FAIL stop_clears_run: got %b want 0", running);
    else passes++;
    n = 0;
    while (cur_code() != 0 && n < 20) begin
      if (stbExec3) saw_e3 = 1;
      tick(0, 0, 0, 1, 1, 0, 0);
      checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL stop_drain cyc %0d: got %h want %h", n, obs_vec(), exp_vec());
      else passes++;
      n++;
    end
    checks++;
    if (!saw_e3 || cycleState !== 4'd0) $display("FAIL stop_completes: got e3=%b state=%0d want 1/0", saw_e3, cycleState);
    else passes++;
  endtask

  task automatic test_irq();
    int n = 0;
    int acks = 0;
    int ovr = 0;
    int ind_in_ovr = 0;
    bit acked = 0;
    bit ind_after = 0;
    tick(1, 0, 0, 1, 0, 0, 0);
    while (cur_code() != 9 && n < 20) begin
      tick(0, 0, 0, 1, 0, 0, 0);
      n++;
    end
    for (int i = 0; i < 30; i++) begin
      tick(0, 0, 0, 1, 0, !acked, 1);
      checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL irq cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      else passes++;
      if (irqAck) begin acks++; acked = 1; end
      if (irqOverride) ovr++;
      if (irqOverride && ckInd) ind_in_ovr++;
      if (acked && !irqOverride && ckInd) ind_after = 1;
    end
    checks++;
    if (acks !== 1 || ovr !== 8 || ind_in_ovr !== 0 || !ind_after)
      $display("FAIL irq_taken: got ack=%0d ovr=%0d ind_in=%0d ind_after=%b want 1/8/0/1",
               acks, ovr, ind_in_ovr, ind_after);
    else passes++;
    tick(0, 1, 0, 1, 0, 0, 0);
    n = 0;
    while (cur_code() != 0 && n < 20) begin tick(0, 0, 0, 1, 0, 0, 0); n++; end
    acks = 0;
    ovr = 0;
    tick(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL irq_disabled cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      else passes++;
      if (irqAck) acks++;
      if (irqOverride) ovr++;
    end
    checks++;
    if (acks !== 0 || ovr !== 0) $display("FAIL irq_masked: got ack=%0d ovr=%0d want 0/0", acks, ovr);
    else passes++;
    tick(0, 1, 0, 0, 0, 0, 0);
    n = 0;
    while (cur_code() != 0 && n < 20) begin tick(0, 0, 0, 0, 0, 0, 0); n++; end
  endtask

  task automatic test_async_reset();
    int n = 0;
    tick(1, 0, 0, 1, 0, 0, 0);
    while (cur_code() != 7 && n < 20) begin
      tick(0, 0, 0, 1, 0, 0, 0);
      n++;
    end
    checks++;
    if (ckInd !== 1'b1) $display("FAIL reach_ick: got %b want 1", ckInd);
    else passes++;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== 21'h0) $display("FAIL async_reset: got %h want %h", obs_vec(), 21'h0);
    else passes++;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs_vec() !== 21'h0) $display("FAIL reset_hold: got %h want %h", obs_vec(), 21'h0);
    else passes++;
    reset_n = 1'b1;
    tick(1, 1, 0, 0, 0, 0, 0);
    checks++;
    if (cycleState !== 4'd0 || running !== 1'b0 || obs_vec() !== exp_vec())
      $display("FAIL start_stop_idle: got %h want %h", obs_vec(), exp_vec());
    else passes++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      tick(($urandom % 12) == 0, ($urandom % 40) == 0, ($urandom % 12) == 0,
           $urandom % 2, $urandom % 2, ($urandom % 3) == 0, $urandom % 2);
      checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL random cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_step_direct();
    test_autoindex_stop();
    test_irq();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and reset_n, with reset_n low forcing reset immediately regardless of clk.
REQ-002 clk  in  1  system clock; all state and outputs SHALL update on its rising edge only.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 start  in  1  one-clock pulse; begin continuous run from IDLE.
REQ-005 stop  in  1  one-clock pulse; halt at the next instruction boundary.
REQ-006 step  in  1  one-clock pulse; execute exactly one instruction from IDLE.
REQ-007 instIsIND, instIsPPIND  in  1 each  IR decode flags, valid during the fetch strobe clock.
REQ-008 irqReq, irqEn  in  1 each  interrupt request level and interrupt-enable level.
REQ-009 ckFetch, stbFetch, ckAuto1, stbAuto1, ckAuto2, stbAuto2, ckInd, stbInd  out  1 each  major-cycle phase signals for the instruction-fetch decoder.
REQ-010 ckExec1, stbExec1, ckExec2, stbExec2, ckExec3, stbExec3  out  1 each  execute-phase signals.
REQ-011 irqOverride  out  1  high for the whole interrupt pseudo-instruction.
REQ-012 irqAck  out  1  one-clock pulse when an interrupt is taken.
REQ-013 running  out  1  run flip-flop state.
REQ-014 cycleState  out  4  current state code (IDLE=0, F_CK=1 ... E3_ST=14, in the order of REQ-016).

Function
REQ-015 All outputs SHALL be registered and driven directly from state.
REQ-016 States SHALL be IDLE, F_CK, F_ST, A1_CK, A1_ST, A2_CK, A2_ST, I_CK, I_ST, E1_CK, E1_ST, E2_CK, E2_ST, E3_CK, E3_ST, each lasting exactly one clock.
REQ-017 Each X_CK state SHALL assert only its ck output; each X_ST state SHALL assert only its stb output.
REQ-018 Exactly one phase output SHALL be high in every non-IDLE state; none SHALL be high in IDLE.
REQ-019 IDLE with step=1 SHALL go to F_CK with running unchanged at 0.
REQ-020 IDLE with start=1 and stop=0 SHALL go to F_CK and set running.
REQ-021 IDLE with start=1 and stop=1 SHALL stay in IDLE; stop wins.
REQ-022 start and step SHALL both be ignored outside IDLE.
REQ-023 If start and step are both high in IDLE, start SHALL take precedence.
REQ-024 F_ST SHALL sample the decode flags on its ending edge: instIsPPIND=1 goes to A1_CK (PPIND wins if both flags are high); else instIsIND=1 goes to I_CK; else to E1_CK.
REQ-025 Flags SHALL be treated as 0 while irqOverride=1.
REQ-026 Autoindex path: A1_CK, A1_ST, A2_CK, A2_ST, I_CK, I_ST, then E1_CK.
REQ-027 Indirect path: I_CK, I_ST, then E1_CK.
REQ-028 Execute path SHALL be E1_CK through E3_ST in order.
REQ-029 Instruction latency SHALL be 8 clocks direct, 10 clocks indirect, 14 clocks autoindex, measured from F_CK entry to E3_ST exit.
REQ-030 stop SHALL clear running at any time.
REQ-031 stop SHALL never abort an instruction in progress.
REQ-032 At the end of E3_ST, if running=1, irqReq=1 and irqEn=1: go to F_CK, set irqOverride, and pulse irqAck during that F_CK.
REQ-033 At the end of E3_ST, otherwise if running=1: go to F_CK with irqOverride=0.
REQ-034 At the end of E3_ST, otherwise: go to IDLE.
REQ-035 irqOverride SHALL stay high from F_CK through E3_ST of the interrupt instruction and clear on exit.
REQ-036 Back-to-back interrupts SHALL be permitted if irqReq and irqEn remain high.
REQ-037 Interrupts SHALL never be taken in step mode (running=0).
REQ-038 irqReq and irqEn SHALL be sampled only at the E3_ST boundary.

Reset
REQ-039 reset_n low SHALL force IDLE, running=0, irqOverride=0, irqAck=0, all phase outputs 0, and cycleState=0, asynchronously.
REQ-040 Reset asserted mid-instruction SHALL abandon the instruction with no further strobes.
REQ-041 After reset_n rises, the block SHALL stay in IDLE until start or step.

Verification
REQ-042 step pulse, both flags 0 -> ckFetch, stbFetch, ckExec1 ... stbExec3 on 8 consecutive clocks, then IDLE, running=0.
REQ-043 start, instIsPPIND=1 on the first instruction -> 14-clock sequence F, A1, A2, I, E1-E3 (ck/stb pairs), then the next F_CK immediately.
REQ-044 start, instIsIND=1 and instIsPPIND=1 together -> autoindex path taken (A1_CK follows F_ST).
REQ-045 Running, stop pulsed during A2_CK -> instruction completes through E3_ST, then IDLE; running=0 from the clock after the pulse.
REQ-046 Running, irqReq=1, irqEn=1 asserted mid-instruction with instIsIND=1 held -> after E3_ST, irqAck is 1 for one clock at F_CK, irqOverride is 1 for 8 clocks, no I_CK occurs; with irqEn=0, no interrupt is taken.
REQ-047 reset_n driven low between clock edges during I_CK -> all outputs 0 before the next edge; start with stop in the same clock -> remains IDLE.
